pc_fetch_stage: RTL and testbench

- Fetch stage of the 16-bit processor. Holds the program counter, fetches one instruction word per PC over a request/ack memory handshake, and presents it to decode.
- Consumes the 16-bit next-PC value chosen by the downstream-of-control 3-way next-PC mux. Produces pc_plus_step, which feeds that mux's sequential input.
- Redirects (branch/jump) load the mux output and discard any in-flight fetch.

---
 rtl/pc_fetch_stage.sv | 199 +++++++++++++++++++
 tb/tb_pc_fetch_stage.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: program counter and instruction fetch for the 16-bit core.
// Issues one request/ack memory fetch per PC, holds the fetched word in ir
// until decode accepts it, and handles redirects by discarding an in-flight
// fetch. A fetch that waits TIMEOUT cycles without an ack locks the stage
// in S_ERR until reset.
// Optional build macro FETCH_TRACE_EN adds simulation-only capture/timeout
// messages; cycle behaviour is identical with or without it.
//
//   state  | meaning
//   S_REQ  | idle, issue a request for pc unless stalled
//   S_WAIT | request outstanding, ack will be captured into ir
//   S_FULL | ir holds a valid instruction, waiting for decode
//   S_DROP | request outstanding after a redirect, ack data is discarded
//   S_ERR  | fetch timed out, terminal until reset
module pc_fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_STEP  = 16'd2,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_next_pc,
    input  logic        i_pc_load,
    input  logic        i_stall,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc_plus_step,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    output logic [15:0] o_ir,
    output logic        o_ir_valid,
    input  logic        i_ir_accept,
    output logic        o_fetch_err
);

    typedef enum logic [2:0] {
        S_REQ  = 3'd0,
        S_WAIT = 3'd1,
        S_FULL = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_req;
    logic [15:0] r_addr;
    logic [15:0] r_ir;
    logic        r_ir_valid;
    logic        r_err;
    logic [7:0]  r_cnt;

    state_t      w_state;
    logic [15:0] w_pc;
    logic        w_req;
    logic [15:0] w_addr;
    logic [15:0] w_ir;
    logic        w_ir_valid;
    logic        w_err;
    logic [7:0]  w_cnt;
    logic        w_timeout;

    assign o_pc           = r_pc;
    assign o_pc_plus_step = r_pc + PC_STEP;
    assign o_imem_req     = r_req;
    assign o_imem_addr    = r_addr;
    assign o_ir           = r_ir;
    assign o_ir_valid     = r_ir_valid;
    assign o_fetch_err    = r_err;

    // Next-state and next-register values; pc_load outranks ack/timeout,
    // which outrank ir_accept, which outranks stall.
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_req      = r_req;
        w_addr     = r_addr;
        w_ir       = r_ir;
        w_ir_valid = r_ir_valid;
        w_err      = r_err;
        w_cnt      = r_cnt;
        w_timeout  = (r_cnt == CNT_LAST);

        case (r_state)
            S_REQ: begin
                if (i_pc_load) begin
                    w_pc       = i_next_pc;
                    w_ir_valid = 1'b0;
                end else if (!i_stall) begin
                    w_req   = 1'b1;
                    w_addr  = r_pc;
                    w_cnt   = 8'd0;
                    w_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_pc_load) begin
                    w_pc       = i_next_pc;
                    w_ir_valid = 1'b0;
                    if (i_imem_ack) begin
                        // Ack on the redirect edge completes the old fetch; drop it.
                        w_req   = 1'b0;
                        w_state = S_REQ;
                    end else begin
                        w_cnt   = 8'd0;
                        w_state = S_DROP;
                    end
                end else if (i_imem_ack) begin
                    w_ir       = i_imem_rdata;
                    w_ir_valid = 1'b1;
                    w_req      = 1'b0;
                    w_state    = S_FULL;
                end else if (w_timeout) begin
                    w_req   = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_ERR;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_FULL: begin
                if (i_pc_load) begin
                    w_pc       = i_next_pc;
                    w_ir_valid = 1'b0;
                    w_state    = S_REQ;
                end else if (i_ir_accept) begin
                    w_pc       = i_next_pc;
                    w_ir_valid = 1'b0;
                    w_state    = S_REQ;
                end
            end
            S_DROP: begin
                if (i_pc_load) begin
                    // Latest redirect wins; the timeout window is held meanwhile.
                    w_pc       = i_next_pc;
                    w_ir_valid = 1'b0;
                    if (i_imem_ack) begin
                        w_req   = 1'b0;
                        w_state = S_REQ;
                    end
                end else if (i_imem_ack) begin
                    w_req   = 1'b0;
                    w_state = S_REQ;
                end else if (w_timeout) begin
                    w_req   = 1'b0;
                    w_err   = 1'b1;
                    w_state = S_ERR;
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end
            S_ERR: begin
                w_req      = 1'b0;
                w_ir_valid = 1'b0;
            end
            default: begin
                w_state = S_REQ;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req      <= 1'b0;
            r_addr     <= 16'h0000;
            r_ir       <= 16'h0000;
            r_ir_valid <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= 8'd0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_req      <= w_req;
            r_addr     <= w_addr;
            r_ir       <= w_ir;
            r_ir_valid <= w_ir_valid;
            r_err      <= w_err;
            r_cnt      <= w_cnt;
        end
    end

`ifdef FETCH_TRACE_EN
    // Simulation trace of instruction captures and timeout entry.
    always @(posedge clk) begin
        if (rst_n && (r_state == S_WAIT) && i_imem_ack && !i_pc_load)
            $display("FETCH pc=%h ir=%h", r_pc, i_imem_rdata);
        if (rst_n && (r_state != S_ERR) && (w_state == S_ERR))
            $display("ERROR! FETCH TIMEOUT pc=%h", r_pc);
    end
`else
`endif

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage built with TIMEOUT=4.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] next_pc;
    logic        pc_load;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus_step;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_accept;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_stage #(
        .RESET_PC (16'h0000),
        .PC_STEP  (16'd2),
        .TIMEOUT  (4)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_next_pc      (next_pc),
        .i_pc_load      (pc_load),
        .i_stall        (stall),
        .o_pc           (pc),
        .o_pc_plus_step (pc_plus_step),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_ack     (imem_ack),
        .i_imem_rdata   (imem_rdata),
        .o_ir           (ir),
        .o_ir_valid     (ir_valid),
        .i_ir_accept    (ir_accept),
        .o_fetch_err    (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One complete zero-wait fetch at address a returning d, accepted at once.
    task automatic fetch_one(input logic [15:0] a, input logic [15:0] d);
        logic [15:0] nxt;
        nxt   = a + 16'd2;
        stall = 1'b0;
        tick();
        check_eq("req_issued", {15'd0, imem_req}, 16'd1);
        check_eq("req_addr", imem_addr, a);
        check_eq("pc_during_fetch", pc, a);
        check_eq("pc_plus_step", pc_plus_step, nxt);
        imem_ack   = 1'b1;
        imem_rdata = d;
        tick();
        imem_ack = 1'b0;
        check_eq("ir_valid_set", {15'd0, ir_valid}, 16'd1);
        check_eq("ir_data", ir, d);
        check_eq("req_dropped", {15'd0, imem_req}, 16'd0);
        ir_accept = 1'b1;
        next_pc   = nxt;
        tick();
        ir_accept = 1'b0;
        check_eq("pc_advanced", pc, nxt);
        check_eq("ir_valid_clr", {15'd0, ir_valid}, 16'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        next_pc    = 16'h0000;
        pc_load    = 1'b0;
        stall      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        ir_accept  = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_req", {15'd0, imem_req}, 16'd0);
        check_eq("rst_addr", imem_addr, 16'h0000);
        check_eq("rst_ir", ir, 16'h0000);
        check_eq("rst_ir_valid", {15'd0, ir_valid}, 16'd0);
        check_eq("rst_err", {15'd0, fetch_err}, 16'd0);
        check_eq("rst_pc_plus_step", pc_plus_step, 16'h0002);
        rst_n = 1'b1;

        // Sequential fetches.
        fetch_one(16'h0000, 16'h1111);
        fetch_one(16'h0002, 16'h2222);

        // Redirect while waiting at 0004; late DEAD ack is discarded.
        tick();
        check_eq("wait4_req", {15'd0, imem_req}, 16'd1);
        check_eq("wait4_addr", imem_addr, 16'h0004);
        pc_load = 1'b1;
        next_pc = 16'h0100;
        tick();
        pc_load = 1'b0;
        check_eq("drop_pc", pc, 16'h0100);
        check_eq("drop_req_held", {15'd0, imem_req}, 16'd1);
        check_eq("drop_addr_held", imem_addr, 16'h0004);
        check_eq("drop_ir_valid", {15'd0, ir_valid}, 16'd0);
        tick();
        check_eq("drop_req_held2", {15'd0, imem_req}, 16'd1);
        tick();
        imem_ack   = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        imem_ack = 1'b0;
        check_eq("drop_req_done", {15'd0, imem_req}, 16'd0);
        check_eq("drop_ir_kept", ir, 16'h2222);
        check_eq("drop_no_valid", {15'd0, ir_valid}, 16'd0);
        fetch_one(16'h0100, 16'hABCD);

        // Stall in S_REQ for 5 cycles.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_no_req", {15'd0, imem_req}, 16'd0);
        end
        stall = 1'b0;
        tick();
        check_eq("unstall_req", {15'd0, imem_req}, 16'd1);
        check_eq("unstall_addr", imem_addr, 16'h0102);

        // Stall during S_WAIT does not block capture.
        stall      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 16'h5A5A;
        tick();
        imem_ack = 1'b0;
        stall    = 1'b0;
        check_eq("stall_wait_valid", {15'd0, ir_valid}, 16'd1);
        check_eq("stall_wait_ir", ir, 16'h5A5A);

        // Hold ir for 3 cycles, then accept and redirect on the same edge.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_valid", {15'd0, ir_valid}, 16'd1);
            check_eq("hold_ir", ir, 16'h5A5A);
            check_eq("hold_pc", pc, 16'h0102);
        end
        ir_accept = 1'b1;
        pc_load   = 1'b1;
        next_pc   = 16'hFFFE;
        tick();
        ir_accept = 1'b0;
        pc_load   = 1'b0;
        check_eq("acc_load_pc", pc, 16'hFFFE);
        check_eq("acc_load_valid", {15'd0, ir_valid}, 16'd0);
        check_eq("wrap_plus_step", pc_plus_step, 16'h0000);

        // Wrap-around fetch.
        fetch_one(16'hFFFE, 16'h7777);
        tick();
        check_eq("wrap_req", {15'd0, imem_req}, 16'd1);
        check_eq("wrap_addr", imem_addr, 16'h0000);

        // Timeout: no ack for 4 waiting cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("to_req_held", {15'd0, imem_req}, 16'd1);
            check_eq("to_err_low", {15'd0, fetch_err}, 16'd0);
        end
        tick();
        check_eq("to_req_drop", {15'd0, imem_req}, 16'd0);
        check_eq("to_err_set", {15'd0, fetch_err}, 16'd1);

        // Late ack and redirect are ignored in S_ERR.
        imem_ack   = 1'b1;
        imem_rdata = 16'hBEEF;
        pc_load    = 1'b1;
        next_pc    = 16'h1234;
        tick();
        imem_ack = 1'b0;
        pc_load  = 1'b0;
        check_eq("err_req", {15'd0, imem_req}, 16'd0);
        check_eq("err_sticky", {15'd0, fetch_err}, 16'd1);
        check_eq("err_pc_kept", pc, 16'h0000);
        check_eq("err_ir_kept", ir, 16'h7777);
        check_eq("err_no_valid", {15'd0, ir_valid}, 16'd0);
        tick();
        check_eq("err_sticky2", {15'd0, fetch_err}, 16'd1);

        // Asynchronous reset clears everything.
        rst_n = 1'b0;
        #1;
        check_eq("rst2_pc", pc, 16'h0000);
        check_eq("rst2_err", {15'd0, fetch_err}, 16'd0);
        check_eq("rst2_ir", ir, 16'h0000);
        check_eq("rst2_addr", imem_addr, 16'h0000);
        check_eq("rst2_req", {15'd0, imem_req}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
